alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 111 +++++++++++
 tb/tb_alu_issue_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes 16-bit instructions, reads an 8x16 register file
// with writeback bypass, and presents operands through a single-entry output register.
module alu_issue_stage #(
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [3:0]           alu_control,
  output logic [2:0]           out_rd,
  input  logic                 wb_en,
  input  logic [2:0]           wb_rd,
  input  logic [15:0]          wb_data,
  output logic [ILL_CNT_W-1:0] ill_count
);

  logic [15:0]          rf_q [8];
  logic [15:0]          rf_d [8];
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          alu_a_q, alu_a_d;
  logic [15:0]          alu_b_q, alu_b_d;
  logic [3:0]           alu_control_q, alu_control_d;
  logic [2:0]           out_rd_q, out_rd_d;
  logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;

  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] rs1_val, rs2_val;
  logic        accept, legal;
  logic        unused_bits;

  assign opcode      = in_instr[15:12];
  assign rd          = in_instr[11:9];
  assign rs1         = in_instr[8:6];
  assign rs2         = in_instr[5:3];
  assign unused_bits = ^in_instr[2:0];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = (opcode <= 4'd5);

  // Same-cycle writeback wins over the stored value; r0 always reads zero.
  always_comb begin
    rs1_val = rf_q[rs1];
    if (wb_en && (wb_rd == rs1)) rs1_val = wb_data;
    if (rs1 == 3'd0) rs1_val = '0;
    rs2_val = rf_q[rs2];
    if (wb_en && (wb_rd == rs2)) rs2_val = wb_data;
    if (rs2 == 3'd0) rs2_val = '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en && (wb_rd != 3'd0)) rf_d[wb_rd] = wb_data;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    out_rd_d      = out_rd_q;
    ill_count_d   = ill_count_q;
    if (accept && legal) begin
      out_valid_d   = 1'b1;
      alu_a_d       = rs1_val;
      alu_b_d       = rs2_val;
      alu_control_d = opcode;
      out_rd_d      = rd;
    end else if (accept) begin
      out_valid_d = 1'b0;
      if (ill_count_q != '1) ill_count_d = ill_count_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
      out_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      out_rd_q      <= '0;
      ill_count_q   <= '0;
    end else begin
      rf_q          <= rf_d;
      out_valid_q   <= out_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      out_rd_q      <= out_rd_d;
      ill_count_q   <= ill_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign out_rd      = out_rd_q;
  assign ill_count   = ill_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_alu_issue_stage;
  localparam int W = 8;
  localparam int ILL_MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [15:0]   in_instr, alu_a, alu_b, wb_data;
  logic [3:0]    alu_control;
  logic [2:0]    out_rd, wb_rd;
  logic [W-1:0]  ill_count;
  logic [W+39:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage #(.ILL_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {out_valid, alu_a, alu_b, alu_control, out_rd, ill_count};

  // Behavioural model state
  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_ctl;
  logic [2:0]  m_rd;
  int          m_ill;

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [15:0] v;
    v = 16'((op << 12) | (rd << 9) | (rs1 << 6) | (rs2 << 3));
    return v;
  endfunction

  function automatic logic [W+39:0] mvec();
    logic [W-1:0] ic;
    ic = W'(m_ill);
    return {m_valid, m_a, m_b, m_ctl, m_rd, ic};
  endfunction

  function automatic logic [15:0] src(input logic [2:0] idx);
    if (idx == 3'd0) return 16'h0000;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_valid = 0; m_a = 0; m_b = 0; m_ctl = 0; m_rd = 0; m_ill = 0;
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; out_ready = 1; in_instr = 16'h0; wb_rd = 0; wb_data = 0;
  endtask

  // Advance one clock; model updates from the inputs that were present at the edge.
  task automatic tick();
    logic acc, nv, wen;
    logic [15:0] na, nb, wd;
    logic [3:0] nctl;
    logic [2:0] nrd, wr;
    int nill;
    acc = in_valid && (!m_valid || out_ready);
    nv = m_valid; na = m_a; nb = m_b; nctl = m_ctl; nrd = m_rd; nill = m_ill;
    if (acc && in_instr[15:12] < 4'd6) begin
      nv = 1; na = src(in_instr[8:6]); nb = src(in_instr[5:3]);
      nctl = in_instr[15:12]; nrd = in_instr[11:9];
    end else if (acc) begin
      nv = 0;
      if (nill < ILL_MAX) nill++;
    end else if (out_ready) begin
      nv = 0;
    end
    wen = wb_en && wb_rd != 3'd0; wr = wb_rd; wd = wb_data;
    @(posedge clk); #1;
    m_valid = nv; m_a = na; m_b = nb; m_ctl = nctl; m_rd = nrd; m_ill = nill;
    if (wen) m_regs[wr] = wd;
  endtask

  task automatic test_reset();
    idle(); rst = 1; model_reset();
    #3;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); rst = 0; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    idle();
    wb_en = 1; wb_rd = 1; wb_data = 16'h0005; tick();
    wb_rd = 2; wb_data = 16'h0003; tick();
    wb_en = 0; in_valid = 1; in_instr = 16'h0250; tick();  // ADD r1,r1,r2
    n_tests++;
    if ({out_valid, alu_a, alu_b, alu_control, out_rd} !== {1'b1, 16'h0005, 16'h0003, 4'h0, 3'd1}) begin
      n_fail++; $display("FAIL add_r1_r1_r2 got v=%b a=%h b=%h c=%h rd=%0d exp v=1 a=0005 b=0003 c=0 rd=1",
                          out_valid, alu_a, alu_b, alu_control, out_rd);
    end
    in_instr = 16'h0288; tick();  // rd=1 rs1=2 rs2=1
    n_tests++;
    if ({out_valid, alu_a, alu_b, alu_control, out_rd} !== {1'b1, 16'h0003, 16'h0005, 4'h0, 3'd1}) begin
      n_fail++; $display("FAIL instr_0288 got v=%b a=%h b=%h rd=%0d exp v=1 a=0003 b=0005 rd=1",
                          out_valid, alu_a, alu_b, out_rd);
    end
    idle(); tick();
    n_tests++;
    if ({out_valid, alu_a, alu_b} !== {1'b0, 16'h0003, 16'h0005}) begin
      n_fail++; $display("FAIL drain_hold got v=%b a=%h b=%h exp v=0 a=0003 b=0005", out_valid, alu_a, alu_b);
    end
  endtask

  task automatic test_bypass();
    idle();
    in_valid = 1; in_instr = mk(1, 4, 3, 1); wb_en = 1; wb_rd = 3; wb_data = 16'h1234; tick();
    n_tests++;
    if ({alu_a, alu_b} !== {16'h1234, 16'h0005}) begin
      n_fail++; $display("FAIL bypass_r3 got a=%h b=%h exp a=1234 b=0005", alu_a, alu_b);
    end
    in_instr = mk(0, 5, 0, 3); wb_rd = 0; wb_data = 16'hFFFF; tick();
    n_tests++;
    if ({alu_a, alu_b} !== {16'h0000, 16'h1234}) begin
      n_fail++; $display("FAIL r0_zero got a=%h b=%h exp a=0000 b=1234", alu_a, alu_b);
    end
    idle(); tick();
  endtask

  task automatic test_stall();
    idle();
    in_valid = 1; in_instr = mk(2, 6, 1, 2); tick();
    out_ready = 0; in_instr = mk(3, 7, 2, 1);
    for (int i = 0; i < 4; i++) begin
      wb_en = 1; wb_rd = (i % 2 == 1) ? 3'd1 : 3'd2; wb_data = 16'($urandom);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tick();
      n_tests++;
      if ({out_valid, alu_a, alu_b, alu_control, out_rd} !== {1'b1, 16'h0005, 16'h0003, 4'h2, 3'd6}) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b a=%h b=%h c=%h rd=%0d exp v=1 a=0005 b=0003 c=2 rd=6",
                            i, out_valid, alu_a, alu_b, alu_control, out_rd);
      end
    end
    wb_en = 0; out_ready = 1; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    tick();
    n_tests++;
    if (dut_vec !== mvec() || alu_control !== 4'h3 || out_rd !== 3'd7) begin
      n_fail++; $display("FAIL stall_release got=%h exp=%h", dut_vec, mvec());
    end
    idle(); tick();
  endtask

  task automatic test_stream();
    idle();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_instr = mk(i % 6, i % 8, (i + 1) % 8, (i + 3) % 8);
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || alu_control !== 4'(i % 6) || out_rd !== 3'(i % 8) || dut_vec !== mvec()) begin
        n_fail++; $display("FAIL stream_%0d got v=%b c=%h rd=%0d vec=%h exp v=1 c=%0d rd=%0d vec=%h",
                            i, out_valid, alu_control, out_rd, dut_vec, i % 6, i % 8, mvec());
      end
    end
    idle(); tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got v=%b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    idle(); tick();
    in_valid = 1; in_instr = mk(9, 1, 1, 1); tick();
    n_tests++;
    if (out_valid !== 1'b0 || ill_count !== W'(1)) begin
      n_fail++; $display("FAIL illegal_one got v=%b ill=%0d exp v=0 ill=1", out_valid, ill_count);
    end
    for (int k = 1; k <= 300; k++) begin
      in_instr = mk(6 + int'($urandom_range(9, 0)), $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0));
      tick();
      if (k == 253) begin
        n_tests++;
        if (ill_count !== W'(254)) begin n_fail++; $display("FAIL illegal_254 got=%0d exp=254", ill_count); end
      end
    end
    n_tests++;
    if (ill_count !== W'(ILL_MAX) || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_sat got ill=%0d v=%b exp ill=%0d v=0", ill_count, out_valid, ILL_MAX);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0; in_instr = 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      wb_en = $urandom % 2; wb_rd = 3'($urandom); wb_data = 16'($urandom);
      #1;
      n_tests++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready);
      end
      tick();
      n_tests++;
      if (dut_vec !== mvec()) begin n_fail++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", i, dut_vec, mvec()); end
    end
    idle(); tick();
  endtask

  task automatic test_reset_stall();
    idle();
    wb_en = 1; wb_rd = 1; wb_data = 16'hAAAA; tick();
    wb_rd = 2; wb_data = 16'h5555; tick();
    wb_en = 0; in_valid = 1; in_instr = mk(4, 3, 1, 2); tick();
    out_ready = 0; in_instr = mk(0, 1, 1, 1); tick();
    n_tests++;
    if ({out_valid, alu_a, alu_b} !== {1'b1, 16'hAAAA, 16'h5555}) begin
      n_fail++; $display("FAIL pre_reset_stall got v=%b a=%h b=%h exp v=1 a=aaaa b=5555", out_valid, alu_a, alu_b);
    end
    #2; rst = 1; #1;
    n_tests++;
    if (dut_vec !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got vec=%h rdy=%b exp vec=0 rdy=1", dut_vec, in_ready);
    end
    model_reset(); in_valid = 0; out_ready = 1;
    @(negedge clk); rst = 0;
    in_valid = 1; in_instr = mk(0, 3, 1, 2); tick();
    n_tests++;
    if ({out_valid, alu_a, alu_b, out_rd} !== {1'b1, 16'h0, 16'h0, 3'd3} || dut_vec !== mvec()) begin
      n_fail++; $display("FAIL post_reset_issue got v=%b a=%h b=%h rd=%0d exp v=1 a=0000 b=0000 rd=3",
                          out_valid, alu_a, alu_b, out_rd);
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_stream();
    test_illegal();
    test_random();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
